// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the x0 register address,
// the writeback result-source encoding and the staged-write record.
package cpu_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [XLEN-1:0]       xlen_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t X0_ADDR = '0;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_LD   = 2'd1,
      SRC_ALU  = 2'd2
   } wb_src_e;

   typedef struct packed {
      logic      en;
      reg_addr_t addr;
      xlen_t     data;
   } wb_wr_t;

   // True when a is a real register (not x0) and names the same register as b.
   function automatic logic reg_match(input reg_addr_t a, input reg_addr_t b);
      return (a != X0_ADDR) && (a == b);
   endfunction

endpackage

// File: rtl/wb_unit_if.sv
// Writeback-unit bus: ALU result handshake, load issue/response, decode hazard
// probe and register-file write port. Forwarding outputs exist only with WB_FWD_EN.
interface wb_unit_if;
   import cpu_pkg::*;

   // ALU handshake: a result transfers on a cycle where i_alu_vld and o_alu_rdy
   // are both high; the producer holds rd/data stable while vld waits for rdy.
   logic      i_alu_vld;
   logic      o_alu_rdy;
   reg_addr_t i_alu_rd;
   xlen_t     i_alu_data;

   logic      i_ld_issue;
   reg_addr_t i_ld_rd;
   logic      i_ld_vld;
   xlen_t     i_ld_data;
   logic      o_ld_full;

   reg_addr_t i_rs1;
   reg_addr_t i_rs2;
   reg_addr_t i_rd;
   logic      o_hazard;

   logic      o_wr_en;
   reg_addr_t o_wr_addr;
   xlen_t     o_wr_data;
   logic      o_err;

`ifdef WB_FWD_EN
   logic      o_fwd1_en;
   logic      o_fwd2_en;
`endif

   modport slave (
      input  i_alu_vld, i_alu_rd, i_alu_data,
      input  i_ld_issue, i_ld_rd, i_ld_vld, i_ld_data,
      input  i_rs1, i_rs2, i_rd,
      output o_alu_rdy, o_ld_full, o_hazard,
      output o_wr_en, o_wr_addr, o_wr_data, o_err
`ifdef WB_FWD_EN
      , output o_fwd1_en, o_fwd2_en
`endif
   );

   modport master (
      output i_alu_vld, i_alu_rd, i_alu_data,
      output i_ld_issue, i_ld_rd, i_ld_vld, i_ld_data,
      output i_rs1, i_rs2, i_rd,
      input  o_alu_rdy, o_ld_full, o_hazard,
      input  o_wr_en, o_wr_addr, o_wr_data, o_err
`ifdef WB_FWD_EN
      , input o_fwd1_en, o_fwd2_en
`endif
   );

endinterface

// File: rtl/wb_unit_ld_tag_fifo.sv
// In-order FIFO of outstanding load destination tags; exposes every slot's
// valid bit and tag so the hazard logic can compare against all of them.
module ld_tag_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  reg_addr_t             push_tag_i,
   input  logic                  pop_i,
   output logic                  full_o,
   output logic                  empty_o,
   output reg_addr_t             head_tag_o,
   output logic [DEPTH-1:0]      vld_o,
   output reg_addr_t [DEPTH-1:0] tag_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [DEPTH-1:0]       vld_q, vld_d;
   reg_addr_t [DEPTH-1:0]  tag_q, tag_d;
   logic                   do_push, do_pop;

   assign full_o     = (cnt_q == CW'(DEPTH));
   assign empty_o    = (cnt_q == '0);
   assign head_tag_o = tag_q[rd_ptr_q];
   assign vld_o      = vld_q;
   assign tag_o      = tag_q;

   // A push into a full FIFO is only legal when the head leaves the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      vld_d    = vld_q;
      tag_d    = tag_q;
      if (do_pop) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PW'(1);
      end
      // Push after pop so a full-FIFO swap re-validates the recycled slot.
      if (do_push) begin
         vld_d[wr_ptr_q] = 1'b1;
         tag_d[wr_ptr_q] = push_tag_i;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         vld_q    <= '0;
         tag_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         vld_q    <= vld_d;
         tag_q    <= tag_d;
      end
   end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: arbitrates load responses over ALU results into one staged
// register-file write and raises decode hazards. WB_FWD_EN adds forward enables.
module wb_unit
   import cpu_pkg::*;
#(
   parameter int LD_DEPTH = 2
) (
   input logic      clk,
   input logic      rst_n,
   wb_unit_if.slave bus
);

   logic                     fifo_full, fifo_empty;
   reg_addr_t                fifo_head;
   logic [LD_DEPTH-1:0]      ent_vld;
   reg_addr_t [LD_DEPTH-1:0] ent_tag;

   logic    ld_pop, ld_push, alu_acc;
   logic    issue_drop, resp_drop;
   wb_src_e src;
   wb_wr_t  wr_q, wr_d;
   logic    err_q, err_d;
   logic    fifo_hit, stg1_hit, stg2_hit;

   // Load responses cannot be back-pressured, so they always win the write port.
   assign bus.o_alu_rdy = !bus.i_ld_vld;
   assign alu_acc       = bus.i_alu_vld && !bus.i_ld_vld;

   assign ld_pop     = bus.i_ld_vld && !fifo_empty;
   assign resp_drop  = bus.i_ld_vld && fifo_empty;
   assign ld_push    = bus.i_ld_issue && (!fifo_full || bus.i_ld_vld);
   assign issue_drop = bus.i_ld_issue && fifo_full && !bus.i_ld_vld;

   ld_tag_fifo #(
      .DEPTH(LD_DEPTH)
   ) u_ld_tag_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (ld_push),
      .push_tag_i (bus.i_ld_rd),
      .pop_i      (ld_pop),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .head_tag_o (fifo_head),
      .vld_o      (ent_vld),
      .tag_o      (ent_tag)
   );

   assign bus.o_ld_full = fifo_full;

   always_comb begin
      src = SRC_NONE;
      if (ld_pop) begin
         src = SRC_LD;
      end else if (alu_acc) begin
         src = SRC_ALU;
      end
   end

   // Address/data follow every accepted result; x0 results only suppress the enable.
   always_comb begin
      wr_d    = wr_q;
      wr_d.en = 1'b0;
      case (src)
         SRC_LD: begin
            wr_d.addr = fifo_head;
            wr_d.data = bus.i_ld_data;
         end
         SRC_ALU: begin
            wr_d.addr = bus.i_alu_rd;
            wr_d.data = bus.i_alu_data;
         end
         default: ;
      endcase
      if (src != SRC_NONE) begin
         wr_d.en = (wr_d.addr != X0_ADDR);
      end
      err_d = err_q | issue_drop | resp_drop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         err_q <= err_d;
      end
   end

   assign bus.o_wr_en   = wr_q.en;
   assign bus.o_wr_addr = wr_q.addr;
   assign bus.o_wr_data = wr_q.data;
   assign bus.o_err     = err_q;

   // Slot valid bits are registered, so the head popped this cycle still matches.
   always_comb begin
      fifo_hit = 1'b0;
      for (int i = 0; i < LD_DEPTH; i++) begin
         if (ent_vld[i] && (reg_match(bus.i_rs1, ent_tag[i]) ||
                            reg_match(bus.i_rs2, ent_tag[i]) ||
                            reg_match(bus.i_rd,  ent_tag[i]))) begin
            fifo_hit = 1'b1;
         end
      end
   end

   assign stg1_hit = wr_q.en && reg_match(bus.i_rs1, wr_q.addr);
   assign stg2_hit = wr_q.en && reg_match(bus.i_rs2, wr_q.addr);

`ifdef WB_FWD_EN
   assign bus.o_fwd1_en = stg1_hit;
   assign bus.o_fwd2_en = stg2_hit;
   assign bus.o_hazard  = fifo_hit;
`else
   assign bus.o_hazard  = fifo_hit || stg1_hit || stg2_hit;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: directed vector table, hand-written reset/forwarding
// sequences, then randomized traffic against a queue-based reference model.
module tb_wb_unit;
   import cpu_pkg::*;

   localparam int D      = 2;
   localparam int W      = 1 + REG_ADDR_W + XLEN;
   localparam int N_VEC  = 18;
   localparam int N_RAND = 600;

   logic clk;
   logic rst_n;

   wb_unit_if bus ();

   wb_unit #(.LD_DEPTH(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int unsigned av, ard, adat, li, lrd, lv, ldat, rs1, rs2, rd;
      int unsigned e_rdy, e_haz, e_full, e_wen, e_waddr, e_wdata, e_err;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: outstanding tags in issue order, plus the visible write port.
   reg_addr_t    m_tags[$];
   logic         m_en;
   reg_addr_t    m_addr;
   xlen_t        m_data;
   logic         m_err;
   logic [W-1:0] exp_q[$];

   vec_t tbl [N_VEC];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int unsigned av, ard, adat, li, lrd, lv, ldat,
                               rs1, rs2, rd);
      vec_t v;
      v = '{default: 0};
      v.av = av;   v.ard = ard; v.adat = adat;
      v.li = li;   v.lrd = lrd;
      v.lv = lv;   v.ldat = ldat;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus.i_alu_vld  = (v.av != 0);
      bus.i_alu_rd   = 5'(v.ard);
      bus.i_alu_data = 32'(v.adat);
      bus.i_ld_issue = (v.li != 0);
      bus.i_ld_rd    = 5'(v.lrd);
      bus.i_ld_vld   = (v.lv != 0);
      bus.i_ld_data  = 32'(v.ldat);
      bus.i_rs1      = 5'(v.rs1);
      bus.i_rs2      = 5'(v.rs2);
      bus.i_rd       = 5'(v.rd);
   endtask

   function automatic logic nz_eq(input reg_addr_t a, input reg_addr_t b);
      return (a != 0) && (a == b);
   endfunction

   function automatic logic m_hazard();
      logic h;
      h = 1'b0;
      foreach (m_tags[i]) begin
         if (nz_eq(bus.i_rs1, m_tags[i]) || nz_eq(bus.i_rs2, m_tags[i]) ||
             nz_eq(bus.i_rd, m_tags[i]))
            h = 1'b1;
      end
`ifndef WB_FWD_EN
      if (m_en && (nz_eq(bus.i_rs1, m_addr) || nz_eq(bus.i_rs2, m_addr)))
         h = 1'b1;
`endif
      return h;
   endfunction

   task automatic model_reset();
      m_tags.delete();
      exp_q.delete();
      m_en   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_err  = 1'b0;
   endtask

   task automatic check_comb_model();
      chk("alu_rdy", 64'(bus.o_alu_rdy), 64'(!bus.i_ld_vld));
      chk("ld_full", 64'(bus.o_ld_full), 64'(m_tags.size() == D));
      chk("hazard",  64'(bus.o_hazard),  64'(m_hazard()));
`ifdef WB_FWD_EN
      chk("fwd1_en", 64'(bus.o_fwd1_en), 64'(m_en && nz_eq(bus.i_rs1, m_addr)));
      chk("fwd2_en", 64'(bus.o_fwd2_en), 64'(m_en && nz_eq(bus.i_rs2, m_addr)));
`endif
   endtask

   task automatic model_step();
      int        sz;
      reg_addr_t t;
      sz   = m_tags.size();
      m_en = 1'b0;
      if (bus.i_ld_vld) begin
         if (sz > 0) begin
            t      = m_tags.pop_front();
            m_addr = t;
            m_data = bus.i_ld_data;
            m_en   = (t != 0);
         end else begin
            m_err = 1'b1;
         end
      end else if (bus.i_alu_vld) begin
         m_addr = bus.i_alu_rd;
         m_data = bus.i_alu_data;
         m_en   = (bus.i_alu_rd != 0);
      end
      if (bus.i_ld_issue) begin
         if (sz < D || bus.i_ld_vld) m_tags.push_back(bus.i_ld_rd);
         else                        m_err = 1'b1;
      end
      exp_q.push_back({m_en, m_addr, m_data});
   endtask

   task automatic check_seq_model();
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard: got empty expected queue, want one entry at %0t", $time);
      end else begin
         e = exp_q.pop_front();
         chk("wr_port", 64'({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data}), 64'(e));
      end
      chk("err", 64'(bus.o_err), 64'(m_err));
   endtask

   task automatic finish_cycle();
      check_comb_model();
      model_step();
      @(posedge clk);
      #1;
      check_seq_model();
   endtask

   task automatic run_cycle(input vec_t v);
      drive(v);
      #1;
      finish_cycle();
   endtask

   task automatic pulse_reset(input int unsigned probe);
      drive(mk(0, 0, 0, 0, 0, 0, 0, probe, probe, probe));
      rst_n = 1'b0;
      #1;
      chk("rst_wr_en",   64'(bus.o_wr_en),   64'(0));
      chk("rst_wr_addr", 64'(bus.o_wr_addr), 64'(0));
      chk("rst_wr_data", 64'(bus.o_wr_data), 64'(0));
      chk("rst_err",     64'(bus.o_err),     64'(0));
      chk("rst_ld_full", 64'(bus.o_ld_full), 64'(0));
      chk("rst_hazard",  64'(bus.o_hazard),  64'(0));
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t v;
      rst_n = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("init_wr_en",   64'(bus.o_wr_en),   64'(0));
      chk("init_wr_addr", 64'(bus.o_wr_addr), 64'(0));
      chk("init_wr_data", 64'(bus.o_wr_data), 64'(0));
      chk("init_err",     64'(bus.o_err),     64'(0));
      chk("init_ld_full", 64'(bus.o_ld_full), 64'(0));
      chk("init_alu_rdy", 64'(bus.o_alu_rdy), 64'(1));
      rst_n = 1'b1;

      //          av ard adat     li lrd lv ldat   rs1 rs2 rd | rdy haz full wen waddr wdata    err
      tbl[0]  = '{0, 0, 0,        0, 0,  0, 0,     0,  0,  0,   1,  0,  0,   0,  0,    0,       0};
      tbl[1]  = '{1, 5, 'h1234,   0, 0,  0, 0,     0,  0,  0,   1,  0,  0,   1,  5,    'h1234,  0};
      tbl[2]  = '{0, 0, 0,        0, 0,  0, 0,     0,  0,  0,   1,  0,  0,   0,  0,    0,       0};
      tbl[3]  = '{0, 0, 0,        1, 3,  0, 0,     0,  0,  0,   1,  0,  0,   0,  0,    0,       0};
      tbl[4]  = '{0, 0, 0,        1, 7,  0, 0,     0,  0,  0,   1,  0,  0,   0,  0,    0,       0};
      tbl[5]  = '{0, 0, 0,        0, 0,  0, 0,     7,  0,  0,   1,  1,  1,   0,  0,    0,       0};
      tbl[6]  = '{0, 0, 0,        0, 0,  1, 'hA,   7,  0,  0,   0,  1,  1,   1,  3,    'hA,     0};
      tbl[7]  = '{1, 9, 'h55,     0, 0,  1, 'hB,   7,  0,  0,   0,  1,  0,   1,  7,    'hB,     0};
      tbl[8]  = '{1, 9, 'h55,     0, 0,  0, 0,     0,  0,  7,   1,  0,  0,   1,  9,    'h55,    0};
      tbl[9]  = '{0, 0, 0,        0, 0,  0, 0,     7,  0,  0,   1,  0,  0,   0,  0,    0,       0};
      tbl[10] = '{1, 0, 'h77,     0, 0,  0, 0,     0,  0,  0,   1,  0,  0,   0,  0,    0,       0};
      tbl[11] = '{0, 0, 0,        0, 0,  1, 'h99,  0,  0,  0,   0,  0,  0,   0,  0,    0,       1};
      tbl[12] = '{0, 0, 0,        1, 2,  0, 0,     0,  0,  0,   1,  0,  0,   0,  0,    0,       1};
      tbl[13] = '{0, 0, 0,        1, 4,  0, 0,     0,  0,  0,   1,  0,  0,   0,  0,    0,       1};
      tbl[14] = '{0, 0, 0,        1, 6,  0, 0,     0,  0,  0,   1,  0,  1,   0,  0,    0,       1};
      tbl[15] = '{0, 0, 0,        0, 0,  1, 'hC,   0,  0,  0,   0,  0,  1,   1,  2,    'hC,     1};
      tbl[16] = '{0, 0, 0,        0, 0,  1, 'hD,   0,  0,  0,   0,  0,  0,   1,  4,    'hD,     1};
      tbl[17] = '{0, 0, 0,        0, 0,  0, 0,     6,  0,  0,   1,  0,  0,   0,  0,    0,       1};

      for (int i = 0; i < N_VEC; i++) begin
         drive(tbl[i]);
         #1;
         chk($sformatf("v%0d_alu_rdy", i), 64'(bus.o_alu_rdy), 64'(tbl[i].e_rdy));
         chk($sformatf("v%0d_hazard", i),  64'(bus.o_hazard),  64'(tbl[i].e_haz));
         chk($sformatf("v%0d_ld_full", i), 64'(bus.o_ld_full), 64'(tbl[i].e_full));
         finish_cycle();
         chk($sformatf("v%0d_wr_en", i), 64'(bus.o_wr_en), 64'(tbl[i].e_wen));
         if (tbl[i].e_wen != 0) begin
            chk($sformatf("v%0d_wr_addr", i), 64'(bus.o_wr_addr), 64'(tbl[i].e_waddr));
            chk($sformatf("v%0d_wr_data", i), 64'(bus.o_wr_data), 64'(tbl[i].e_wdata));
         end
         chk($sformatf("v%0d_err", i), 64'(bus.o_err), 64'(tbl[i].e_err));
      end

      // Two loads outstanding, then reset arrives mid-operation.
      run_cycle(mk(0, 0, 0, 1, 10, 0, 0, 0, 0, 0));
      run_cycle(mk(0, 0, 0, 1, 11, 0, 0, 0, 0, 0));
      drive(mk(0, 0, 0, 0, 0, 0, 0, 11, 0, 0));
      #1;
      chk("pre_rst_full",   64'(bus.o_ld_full), 64'(1));
      chk("pre_rst_hazard", 64'(bus.o_hazard),  64'(1));
      pulse_reset(11);
      run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 11, 0, 0));
      chk("post_rst_err", 64'(bus.o_err), 64'(0));
      run_cycle(mk(0, 0, 0, 0, 0, 1, 'h5, 0, 0, 0));
      chk("late_resp_err", 64'(bus.o_err), 64'(1));

      // Staged write to x4 seen by a decode reading x4 as rs2.
      run_cycle(mk(1, 4, 'h44, 0, 0, 0, 0, 0, 0, 0));
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 0));
      #1;
`ifdef WB_FWD_EN
      chk("stage_fwd2_en", 64'(bus.o_fwd2_en), 64'(1));
      chk("stage_fwd1_en", 64'(bus.o_fwd1_en), 64'(0));
      chk("stage_hazard",  64'(bus.o_hazard),  64'(0));
`else
      chk("stage_hazard",  64'(bus.o_hazard),  64'(1));
`endif
      chk("stage_wr_data", 64'(bus.o_wr_data), 64'('h44));
      finish_cycle();

      pulse_reset(0);
      for (int n = 0; n < N_RAND; n++) begin
         if (n % 150 == 149) pulse_reset($urandom_range(0, 7));
         v      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         v.av   = ($urandom_range(0, 99) < 50) ? 1 : 0;
         v.ard  = $urandom_range(0, 7);
         v.adat = $urandom;
         v.li   = ($urandom_range(0, 99) < 40) ? 1 : 0;
         v.lrd  = $urandom_range(0, 7);
         if (m_tags.size() > 0) v.lv = ($urandom_range(0, 99) < 45) ? 1 : 0;
         else                   v.lv = ($urandom_range(0, 99) < 3) ? 1 : 0;
         v.ldat = $urandom;
         v.rs1  = $urandom_range(0, 7);
         v.rs2  = $urandom_range(0, 7);
         v.rd   = $urandom_range(0, 7);
         run_cycle(v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
